// File: rtl/comm_pkg.sv
// -----------------------------------------------------------------------------
// comm_pkg
// Shared definitions for the UART transmit path: arbiter state encodings,
// the idle line byte presented to uart_tx, and the default lock timeout.
// No ports (package).
// -----------------------------------------------------------------------------
package comm_pkg;

  // Arbiter state encodings
  localparam logic [1:0] ARB_IDLE      = 2'd0;
  localparam logic [1:0] ARB_ISSUE     = 2'd1;
  localparam logic [1:0] ARB_GUARD     = 2'd2;
  localparam logic [1:0] ARB_WAIT_DONE = 2'd3;

  // Byte driven towards uart_tx while nothing has been issued
  localparam logic [7:0] TX_IDLE_BYTE = 8'hFF;

  // Cycles an owner may stall mid-packet before its lock is reclaimed
  localparam int DEFAULT_LOCK_TIMEOUT = 4096;

endpackage : comm_pkg

// File: rtl/tx_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin picker. Searches the request vector
// cyclically starting at ptr+1 and returns the first set index.
//
// Ports:
//   req     in  N_REQ   request vector
//   ptr     in  IDX_W   index of the previous winner
//   winner  out N_REQ   one-hot winner (all zero when nothing requested)
//   idx     out IDX_W   binary index of the winner
//   found   out 1       at least one request present
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int N_REQ = 2,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] winner,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // NOTE: every output gets a default before the search loop, so no path
  // through the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    int cand;
    winner = '0;
    idx    = '0;
    found  = 1'b0;
    cand   = 0;
    // Offsets 1..N_REQ visit every index once, ending on ptr itself, so the
    // previous winner is considered last.
    for (int k = 1; k <= N_REQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!found && req[cand[IDX_W-1:0]]) begin
        found                    = 1'b1;
        winner[cand[IDX_W-1:0]] = 1'b1;
        idx                      = cand[IDX_W-1:0];
      end
    end
  end

endmodule : rr_pick

// File: rtl/tx_arbiter.sv
// -----------------------------------------------------------------------------
// tx_arbiter
// Shares one uart_tx byte transmitter between N_REQ byte-stream requesters.
// Round-robin arbitration with packet lock: the owner keeps the transmitter
// until its byte flagged last has been sent, or until it stalls mid-packet
// for LOCK_TIMEOUT cycles, in which case the lock is reclaimed.
//
// Ports:
//   clk            in   1        system clock
//   rst            in   1        asynchronous active-high reset
//   req_valid      in   N_REQ    requester i has a byte on its req_data slice
//   req_data       in   8*N_REQ  byte of requester i at [8*i +: 8]
//   req_last       in   N_REQ    byte of requester i ends its packet
//   req_ready      out  N_REQ    one-cycle pulse: byte of requester i accepted
//   grant          out  N_REQ    one-hot current owner, zero when no owner
//   timeout        out  1        one-cycle pulse on forced lock release
//   tx_data        out  8        byte to uart_tx
//   tx_data_ready  out  1        one-cycle start strobe to uart_tx
//   tx_done        in   1        uart_tx idle/finished (high when idle)
// -----------------------------------------------------------------------------
module tx_arbiter
  import comm_pkg::*;
#(
  parameter int N_REQ        = 2,
  parameter int LOCK_TIMEOUT = DEFAULT_LOCK_TIMEOUT,
  parameter int TO_W         = $clog2(LOCK_TIMEOUT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   grant,
  output logic               timeout,
  output logic [7:0]         tx_data,
  output logic               tx_data_ready,
  input  logic               tx_done
);

  localparam int              IDX_W    = $clog2(N_REQ);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(LOCK_TIMEOUT);

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic             last_q, last_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;

  logic [N_REQ-1:0] grant_d, req_ready_d;
  logic [7:0]       tx_data_d;
  logic             tx_data_ready_d, timeout_d;

  logic [N_REQ-1:0] pick_winner;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;

  logic [7:0]       data_arr [N_REQ];
  logic             owner_valid, owner_last;
  logic [7:0]       owner_data;
  logic [TO_W-1:0]  to_inc;
  logic             to_expire;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req    (req_valid),
    .ptr    (ptr_q),
    .winner (pick_winner),
    .idx    (pick_idx),
    .found  (pick_found)
  );

  always_comb begin
    for (int i = 0; i < N_REQ; i++) data_arr[i] = req_data[8*i +: 8];
  end

  assign owner_valid = req_valid[owner_q];
  assign owner_last  = req_last[owner_q];
  assign owner_data  = data_arr[owner_q];

  // Saturating stall counter; expiry is judged on the incremented value so the
  // release happens on the LOCK_TIMEOUT-th stalled ISSUE cycle.
  assign to_inc    = (to_cnt_q == TO_LIMIT) ? to_cnt_q : to_cnt_q + TO_W'(1);
  assign to_expire = (to_inc == TO_LIMIT);

  // State and output registers. Reset mid-byte simply drops the byte: the
  // pulse registers clear, so the requester never sees req_ready for it.
  // NOTE: non-blocking assignments here so every register samples the values
  // from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ARB_IDLE;
      ptr_q         <= IDX_W'(N_REQ - 1);
      owner_q       <= '0;
      last_q        <= 1'b0;
      to_cnt_q      <= '0;
      grant         <= '0;
      req_ready     <= '0;
      timeout       <= 1'b0;
      tx_data       <= TX_IDLE_BYTE;
      tx_data_ready <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      owner_q       <= owner_d;
      last_q        <= last_d;
      to_cnt_q      <= to_cnt_d;
      grant         <= grant_d;
      req_ready     <= req_ready_d;
      timeout       <= timeout_d;
      tx_data       <= tx_data_d;
      tx_data_ready <= tx_data_ready_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:      if (pick_found) state_d = ARB_ISSUE;
      ARB_ISSUE: begin
        if (tx_done && owner_valid)      state_d = ARB_GUARD;
        else if (!owner_valid && to_expire) state_d = ARB_IDLE;
      end
      // uart_tx only drops tx_done the cycle after it samples the strobe, so
      // tx_done is not trusted during this one cycle.
      ARB_GUARD:     state_d = ARB_WAIT_DONE;
      ARB_WAIT_DONE: if (tx_done) state_d = last_q ? ARB_IDLE : ARB_ISSUE;
      default:       state_d = ARB_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath state
  always_comb begin
    ptr_d           = ptr_q;
    owner_d         = owner_q;
    last_d          = last_q;
    to_cnt_d        = to_cnt_q;
    grant_d         = grant;
    tx_data_d       = tx_data;
    req_ready_d     = '0;
    tx_data_ready_d = 1'b0;
    timeout_d       = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          grant_d  = pick_winner;
          ptr_d    = pick_idx;
          owner_d  = pick_idx;
          to_cnt_d = '0;
        end
      end
      ARB_ISSUE: begin
        if (tx_done && owner_valid) begin
          tx_data_d       = owner_data;
          tx_data_ready_d = 1'b1;
          req_ready_d     = grant;  // grant is the owner's one-hot
          last_d          = owner_last;
          to_cnt_d        = '0;
        end else if (!owner_valid) begin
          to_cnt_d = to_inc;
          if (to_expire) begin
            grant_d   = '0;
            timeout_d = 1'b1;
          end
        end
      end
      ARB_WAIT_DONE: begin
        if (tx_done && last_q) grant_d = '0;
      end
      default: ;
    endcase
  end

endmodule : tx_arbiter

// File: tb/tb_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tx_arbiter
// Directed bench for tx_arbiter with N_REQ=2 and LOCK_TIMEOUT=16. The main
// process drives requester scripts and pushes the expected transmit order into
// a scoreboard; a monitor pops and compares on every strobe. A behavioural
// uart_tx model drops tx_done for frame_len cycles after each strobe.
// -----------------------------------------------------------------------------
module tb_tx_arbiter;
  import comm_pkg::*;

  localparam int N    = 2;
  localparam int LT   = 16;
  localparam int MAXB = 8;

  typedef struct {
    int         idx;
    logic [7:0] data;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data  = '0;
  logic [N-1:0]   req_last  = '0;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   grant;
  logic           timeout;
  logic [7:0]     tx_data;
  logic           tx_data_ready;
  logic           tx_done;

  int   n_checks  = 0;
  int   n_fail    = 0;
  int   n_timeout = 0;
  int   frame_len = 8;
  bit   mon_en    = 1'b0;
  exp_t exp_q[$];

  // Requester scripts: byte, last flag, and idle cycles before presenting it
  logic [7:0] s_data [N][MAXB];
  logic       s_last [N][MAXB];
  int         s_gap  [N][MAXB];
  int         s_len  [N];
  int         s_pos  [N];
  int         s_wait [N];

  tx_arbiter #(
    .N_REQ        (N),
    .LOCK_TIMEOUT (LT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .grant         (grant),
    .timeout       (timeout),
    .tx_data       (tx_data),
    .tx_data_ready (tx_data_ready),
    .tx_done       (tx_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // uart_tx model: busy for frame_len cycles after seeing the strobe
  initial begin
    int busy;
    busy    = 0;
    tx_done = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_data_ready && !rst) begin
        tx_done = 1'b0;
        busy    = frame_len;
      end else if (busy > 0) begin
        busy--;
        if (busy == 0) tx_done = 1'b1;
      end
    end
  end

  // Scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && !rst) begin
        if (timeout) n_timeout++;
        if (tx_data_ready || req_ready != '0) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_strobe: tx_data=0x%0h req_ready=%b, expected no strobe (t=%0t)",
                     tx_data, req_ready, $time);
          end else begin
            e = exp_q.pop_front();
            check("sb_strobe",    tx_data_ready, 1);
            check("sb_tx_data",   tx_data,       e.data);
            check("sb_req_ready", req_ready,     32'd1 << e.idx);
            check("sb_grant",     grant,         32'd1 << e.idx);
          end
        end
      end
    end
  end

  task automatic add_byte(input int i, input logic [7:0] d, input logic l, input int gap);
    if (s_pos[i] == s_len[i]) s_wait[i] = gap;
    s_data[i][s_len[i]] = d;
    s_last[i][s_len[i]] = l;
    s_gap[i][s_len[i]]  = gap;
    s_len[i]++;
  endtask

  task automatic expect_tx(input int i, input logic [7:0] d);
    exp_q.push_back('{idx: i, data: d});
  endtask

  // One requester-side cycle: retire acked bytes, present the next ones
  task automatic service();
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        req_valid[i] = 1'b0;
        s_pos[i]++;
        if (s_pos[i] < s_len[i]) s_wait[i] = s_gap[i][s_pos[i]];
      end
      if (!req_valid[i] && s_pos[i] < s_len[i]) begin
        if (s_wait[i] > 0) s_wait[i]--;
        else begin
          req_valid[i]      = 1'b1;
          req_data[8*i +: 8] = s_data[i][s_pos[i]];
          req_last[i]       = s_last[i][s_pos[i]];
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
    service();
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    for (int i = 0; i < N; i++) begin
      s_len[i]  = 0;
      s_pos[i]  = 0;
      s_wait[i] = 0;
    end
    exp_q.delete();
  endtask

  // Assert reset, check outputs immediately, hold two cycles, release
  task automatic do_reset(input string name);
    rst = 1'b1;
    clear_reqs();
    #1;
    check({name, "_tx_data"},       tx_data,       TX_IDLE_BYTE);
    check({name, "_tx_data_ready"}, tx_data_ready, 0);
    check({name, "_req_ready"},     req_ready,     0);
    check({name, "_grant"},         grant,         0);
    check({name, "_timeout"},       timeout,       0);
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k;
    k = 0;
    while (!(exp_q.size() == 0 && grant == '0 && tx_done) && k < budget) begin
      step();
      k++;
    end
    check(name, (k < budget) ? 1 : 0, 1);
  endtask

  initial begin
    int k;
    int lat;
    int t0;
    bit bad;

    @(negedge clk);
    #1;
    mon_en = 1'b1;

    // Single requester, 3-byte packet
    do_reset("rst0");
    add_byte(0, 8'h01, 1'b0, 0);
    add_byte(0, 8'h02, 1'b0, 0);
    add_byte(0, 8'h03, 1'b1, 0);
    expect_tx(0, 8'h01);
    expect_tx(0, 8'h02);
    expect_tx(0, 8'h03);
    wait_idle(200, "t1_done");
    check("t1_grant_released", grant, 0);

    // Contention from reset, then round-robin on a fresh simultaneous round
    do_reset("rst2");
    add_byte(0, 8'hAA, 1'b0, 0);
    add_byte(0, 8'hAB, 1'b1, 0);
    add_byte(1, 8'hBA, 1'b0, 0);
    add_byte(1, 8'hBB, 1'b1, 0);
    expect_tx(0, 8'hAA);
    expect_tx(0, 8'hAB);
    expect_tx(1, 8'hBA);
    expect_tx(1, 8'hBB);
    wait_idle(300, "t2_round1_done");
    add_byte(0, 8'hC0, 1'b1, 0);
    expect_tx(0, 8'hC0);
    wait_idle(100, "t2_single_done");
    add_byte(0, 8'hC1, 1'b1, 0);
    add_byte(1, 8'hD1, 1'b1, 0);
    expect_tx(1, 8'hD1);
    expect_tx(0, 8'hC1);
    wait_idle(200, "t2_round2_done");

    // Lock hold: owner pauses mid-packet while requester 1 waits
    do_reset("rst3");
    t0 = n_timeout;
    add_byte(0, 8'h10, 1'b0, 0);
    add_byte(0, 8'h11, 1'b1, 12);
    add_byte(1, 8'h20, 1'b1, 0);
    expect_tx(0, 8'h10);
    expect_tx(0, 8'h11);
    expect_tx(1, 8'h20);
    k = 0;
    while (exp_q.size() > 2 && k < 50) begin
      step();
      k++;
    end
    check("t3_first_byte", exp_q.size(), 2);
    repeat (10) step();
    check("t3_grant_held", grant, 2'b01);
    check("t3_no_ack_req1", req_ready, 0);
    wait_idle(300, "t3_done");
    check("t3_no_timeout", n_timeout - t0, 0);

    // Timeout: owner goes silent after a non-last byte
    do_reset("rst4");
    t0 = n_timeout;
    add_byte(0, 8'h30, 1'b0, 0);
    add_byte(0, 8'h31, 1'b1, 1000);
    add_byte(1, 8'h40, 1'b1, 0);
    expect_tx(0, 8'h30);
    expect_tx(1, 8'h40);
    k = 0;
    while (exp_q.size() > 1 && k < 60) begin
      step();
      k++;
    end
    check("t4_first_byte", exp_q.size(), 1);
    k = 0;
    while (!tx_done && k < 60) begin
      step();
      k++;
    end
    // tx_done rise seen here; ISSUE is entered on the next edge and the
    // release is visible one negedge after the 16th stalled ISSUE edge.
    lat = 0;
    while (!timeout && lat < 40) begin
      step();
      lat++;
    end
    check("t4_timeout_latency", lat, LT + 1);
    check("t4_grant_cleared", grant, 0);
    step();
    check("t4_timeout_single", timeout, 0);
    check("t4_req1_granted", grant, 2'b10);
    wait_idle(100, "t4_done");
    check("t4_timeout_count", n_timeout - t0, 1);

    // Slow uart: tx_done held low 50 cycles after the strobe
    do_reset("rst5");
    frame_len = 50;
    add_byte(0, 8'h50, 1'b0, 0);
    add_byte(0, 8'h51, 1'b1, 0);
    expect_tx(0, 8'h50);
    expect_tx(0, 8'h51);
    k = 0;
    while (exp_q.size() > 1 && k < 60) begin
      step();
      k++;
    end
    check("t5_first_byte", exp_q.size(), 1);
    bad = 1'b0;
    step();
    k = 0;
    while (!tx_done && k < 100) begin
      if (tx_data_ready || tx_data != 8'h50) bad = 1'b1;
      step();
      k++;
    end
    check("t5_quiet_while_busy", bad, 0);
    check("t5_tx_data_held", tx_data, 8'h50);
    check("t5_no_strobe_at_done", tx_data_ready, 0);
    step();
    check("t5_no_strobe_exit", tx_data_ready, 0);
    step();
    check("t5_strobe_after_issue", tx_data_ready, 1);
    frame_len = 8;
    wait_idle(200, "t5_done");

    // Reset in the middle of a packet
    do_reset("rst6");
    add_byte(0, 8'h60, 1'b0, 0);
    add_byte(0, 8'h61, 1'b0, 0);
    add_byte(0, 8'h62, 1'b1, 0);
    add_byte(1, 8'h70, 1'b1, 0);
    expect_tx(0, 8'h60);
    k = 0;
    while (exp_q.size() > 0 && k < 60) begin
      step();
      k++;
    end
    check("t6_first_byte", exp_q.size(), 0);
    repeat (3) step();
    do_reset("t6_midrst");
    add_byte(0, 8'h80, 1'b1, 0);
    add_byte(1, 8'h90, 1'b1, 0);
    expect_tx(0, 8'h80);
    expect_tx(1, 8'h90);
    wait_idle(200, "t6_done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_tx_arbiter

// File: doc/tx_arbiter.md
Name: tx_arbiter

Overview:
- Shares the single uart_tx byte transmitter between N_REQ byte-stream requesters, e.g. the command-response FIFO and a pin-change event reporter.
- Round-robin arbitration with packet lock: a granted requester keeps the transmitter until its byte flagged last has been sent.
- A lock timeout reclaims the transmitter from a stalled owner.
- Sits between the requesters and uart_tx; drives uart_tx's data/strobe inputs and consumes its tx_done.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- LOCK_TIMEOUT, 4096, cycles an owner may hold the lock mid-packet with req_valid low before forced release.
- TO_W, $clog2(LOCK_TIMEOUT+1), timeout counter width (derived).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  requester i has a byte on its req_data slice.
- req_data  in  8*N_REQ  byte of requester i at [8*i +: 8].
- req_last  in  N_REQ  byte of requester i ends its packet.
- req_ready  out  N_REQ  one-cycle pulse: byte of requester i accepted.
- grant  out  N_REQ  one-hot current owner; all zero when no owner.
- timeout  out  1  one-cycle pulse on forced lock release.
- tx_data  out  8  byte to uart_tx.
- tx_data_ready  out  1  one-cycle start strobe to uart_tx.
- tx_done  in  1  uart_tx idle/finished (high when idle).

Behaviour:
- Reset values (async): tx_data=8'hFF, tx_data_ready=0, req_ready=0, grant=0, timeout=0, state=IDLE, rr pointer=N_REQ-1 (requester 0 wins first), timeout counter=0. Reset mid-byte abandons that byte; no req_ready is issued for it.
- All outputs are registered.
- IDLE:
  - If any req_valid, pick the first valid index searching cyclically from pointer+1.
  - Set grant one-hot, pointer<=winner, go to ISSUE.
  - Arbitration costs 1 cycle.
- ISSUE (owner o):
  - If tx_done && req_valid[o]: tx_data<=req_data[o], tx_data_ready<=1, req_ready[o]<=1, latch last_r<=req_last[o], clear timeout counter, go to GUARD.
  - Else if !req_valid[o]: increment timeout counter. When it reaches LOCK_TIMEOUT: grant<=0, timeout<=1, go to IDLE.
  - Else (valid but !tx_done): wait; the counter does not advance.
- GUARD: exactly 1 cycle; tx_done is ignored here because uart_tx drops it the cycle after sampling the strobe. Go to WAIT_DONE.
- WAIT_DONE:
  - On tx_done=1: if last_r, grant<=0 and go to IDLE; else go to ISSUE.
- Strobe rules:
  - tx_data_ready and req_ready are high for exactly one cycle and are asserted together.
  - tx_data holds its value until the next ISSUE capture.
- Requester rule: hold req_valid/req_data/req_last stable until req_ready is seen. Capture is the cycle before req_ready is visible, so the requester changes data on the edge after the pulse. The controller never samples that requester again before WAIT_DONE ends.
- A requester dropping req_valid mid-packet keeps its lock (subject to timeout). Non-owners are never acked while a lock is held.
- Simultaneous requests: round-robin from pointer+1 only. A requester cannot win twice in a row while another is valid at IDLE.
- Owner last byte with another requester already valid: IDLE re-arbitrates the next cycle; the gap between packets is 1 IDLE cycle plus transmit time.
- Throughput: one byte per uart frame plus 3 cycles of overhead (ISSUE, GUARD, WAIT_DONE exit).
- Timeout counter saturates at LOCK_TIMEOUT; timeout pulses once per release.

Decomposition:
- Shared package comm_pkg holds:
  - state encodings (ARB_IDLE, ARB_ISSUE, ARB_GUARD, ARB_WAIT_DONE) as 2-bit localparams;
  - TX_IDLE_BYTE = 8'hFF;
  - default LOCK_TIMEOUT.
- One sub-module: rr_pick. Purely combinational: inputs req vector and pointer; outputs one-hot winner and index, with cyclic search from pointer+1. Reused by future pin-event schedulers.

Test Plan:
- Single requester: req 0 sends 3-byte packet 8'h01,8'h02,8'h03 (last on 03) -> three tx_data_ready pulses carrying 01,02,03 in order; req_ready[0] coincident with each; grant returns to 0 after third tx_done.
- Contention: req 0 and req 1 both valid from reset with 2-byte packets AA,AB and BA,BB -> tx order AA,AB,BA,BB; a second simultaneous round then grants req 1 first (round-robin).
- Lock hold: req 0 sends byte 10 (not last) then drops valid for 100 cycles while req 1 is valid -> no req_ready[1], grant stays 01; req 0 sends 11 (last) -> then req 1 is served.
- Timeout (LOCK_TIMEOUT=16): req 0 sends non-last byte then goes silent -> timeout pulses exactly once 16 cycles after entering ISSUE idle; grant clears; req 1 is granted the next cycle.
- Slow uart: hold tx_done low 50 cycles after the strobe -> no second tx_data_ready until tx_done rises; tx_data stable throughout.
- Reset mid-packet: assert rst during WAIT_DONE -> tx_data=FF, grant=0, all strobes 0 immediately; after release, requester 0 wins first arbitration.
